// File: rtl/comb_mult_pkg.sv
// Shared definitions for the array multiplier: default operand width,
// product-width helper and the product word type at the default width.
// No logic, no latency, no backpressure: declarations only.
package comb_mult_pkg;

    localparam int DEFAULT_N = 8;

    // Product of two n-bit operands always fits in 2n bits.
    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

    typedef logic [2*DEFAULT_N-1:0] prod_t;

endpackage

// File: rtl/comb_mult_fa_cell.sv
// One-bit full adder, the building block of the multiplier array.
// Purely combinational, zero latency.
// No backpressure: always produces s/cout from the current a, b, cin.
//
// Ports: a, b, cin - addend bits; s - sum bit; cout - carry out.
module comb_mult_fa_cell
    import comb_mult_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/comb_multiplier.sv
// n x n array multiplier: AND partial products, n-1 carry-save full-adder
// rows and a ripple-carry row, registered into a 2n-bit product Q.
// Latency 1 cycle, one product per cycle; no handshake, Q holds while A/B hold.
//
// Ports: clock - rising-edge clock; reset - synchronous active-high, clears Q;
//        A, B - n-bit operands; Q - 2n-bit registered product
//        (Q[n-1:0] low half, Q[2n-1:n] high half).
// Build option: define COMBMULT_SIGNED_EN for two's-complement operands
// (Baugh-Wooley array); otherwise operands are unsigned.
module comb_multiplier
    import comb_mult_pkg::*;
#(
    parameter int n = DEFAULT_N
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [n-1:0]             A,
    input  logic [n-1:0]             B,
    output logic [prod_width(n)-1:0] Q
);

    localparam int PW = prod_width(n);

`ifdef COMBMULT_SIGNED_EN
    // Baugh-Wooley: invert partial products where exactly one operand
    // index is the sign bit, and add constant 1s at weights n and 2n-1.
    localparam logic BW_EN = 1'b1;
`else
    localparam logic BW_EN = 1'b0;
`endif

    logic [n-1:0]  pp        [n];
    logic [n-1:0]  sum_row   [1:n-1];
    logic [n-1:0]  carry_row [1:n-1];
    logic [n-2:0]  rip_c;
    logic [PW-1:0] prod;

    // pp[i][j] has weight i+j.
    for (genvar i = 0; i < n; i++) begin : g_pp_row
        for (genvar j = 0; j < n; j++) begin : g_pp_col
            assign pp[i][j] = (A[j] & B[i]) ^ (BW_EN & ((i == n-1) != (j == n-1)));
        end
    end

    assign prod[0] = pp[0][0];

    // Carry-save rows. Cell (i,j) has weight i+j; it adds pp[i][j], the
    // previous row's sum from one column to the left, and the previous
    // row's carry from the same column. Each row retires one low bit.
    for (genvar i = 1; i < n; i++) begin : g_row
        for (genvar j = 0; j < n; j++) begin : g_cell
            logic b_in;
            logic c_in;

            if (j < n-1) begin : g_b_inner
                if (i == 1) begin : g_b_first
                    assign b_in = pp[0][j+1];
                end else begin : g_b_next
                    assign b_in = sum_row[i-1][j+1];
                end
            end else begin : g_b_msb
                // Row 1, leftmost cell sits at weight n: Baugh-Wooley constant.
                assign b_in = (i == 1) ? BW_EN : 1'b0;
            end

            if (i == 1) begin : g_c_first
                assign c_in = 1'b0;
            end else begin : g_c_next
                assign c_in = carry_row[i-1][j];
            end

            comb_mult_fa_cell u_fa (
                .a    (pp[i][j]),
                .b    (b_in),
                .cin  (c_in),
                .s    (sum_row[i][j]),
                .cout (carry_row[i][j])
            );
        end

        assign prod[i] = sum_row[i][0];
    end

    // Ripple row merges the last row's sums and carries into the upper bits.
    for (genvar k = 0; k < n-1; k++) begin : g_rip
        logic cin_k;

        if (k == 0) begin : g_rc_first
            assign cin_k = 1'b0;
        end else begin : g_rc_next
            assign cin_k = rip_c[k-1];
        end

        comb_mult_fa_cell u_fa (
            .a    (sum_row[n-1][k+1]),
            .b    (carry_row[n-1][k]),
            .cin  (cin_k),
            .s    (prod[n+k]),
            .cout (rip_c[k])
        );
    end

    // Top bit: the carry out of bit 2n-1 is beyond the product width, so
    // only the sum is formed (plus the Baugh-Wooley constant at 2n-1).
    assign prod[PW-1] = BW_EN ^ carry_row[n-1][n-1] ^ rip_c[n-2];

    always_ff @(posedge clock) begin
        if (reset) begin
            Q <= '0;
        end else begin
            Q <= prod;
        end
    end

endmodule

// File: tb/tb_comb_multiplier.sv
module tb_comb_multiplier;
    import comb_mult_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] q8;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  q4;

    int n_cmp;
    int n_bad;

    logic [15:0] exp8_q [$];
    logic [7:0]  exp4_q [$];

    typedef struct {
        logic        rst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    comb_multiplier #(.n(8)) u_dut8 (
        .clock (clock),
        .reset (reset),
        .A     (a8),
        .B     (b8),
        .Q     (q8)
    );

    comb_multiplier #(.n(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .A     (a4),
        .B     (b4),
        .Q     (q4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] r;
`ifdef COMBMULT_SIGNED_EN
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
`else
        sa = {8'b0, a};
        sb = {8'b0, b};
`endif
        r = sa * sb;
        return r;
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic signed [7:0] r;
`ifdef COMBMULT_SIGNED_EN
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
`else
        sa = {4'b0, a};
        sb = {4'b0, b};
`endif
        r = sa * sb;
        return r;
    endfunction

    // Drive one set of operands (inputs change on the falling edge), queue
    // the expected products, then check both DUTs one rising edge later.
    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] want8, input logic [3:0] x4,
                        input logic [3:0] y4, input string nm);
        logic [15:0] e8;
        logic [7:0]  e4;
        reset = r;
        a8    = a;
        b8    = b;
        a4    = x4;
        b4    = y4;
        exp8_q.push_back(r ? 16'h0000 : want8);
        exp4_q.push_back(r ? 8'h00 : ref4(x4, y4));
        @(posedge clock);
        @(negedge clock);
        e8 = exp8_q.pop_front();
        e4 = exp4_q.pop_front();
        n_cmp++;
        if (q8 !== e8) begin
            n_bad++;
            $display("FAIL %s n8: A=%h B=%h Q=%h expected %h", nm, a, b, q8, e8);
        end
        n_cmp++;
        if (q4 !== e4) begin
            n_bad++;
            $display("FAIL %s n4: A=%h B=%h Q=%h expected %h", nm, x4, y4, q4, e4);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;

`ifdef COMBMULT_SIGNED_EN
        vecs[0]  = '{1'b1, 8'h5A, 8'h3C, 16'h0000, "reset0"};
        vecs[1]  = '{1'b1, 8'h5A, 8'h3C, 16'h0000, "reset1"};
        vecs[2]  = '{1'b0, 8'h5A, 8'h3C, 16'h1518, "release"};
        vecs[3]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C, "12x13"};
        vecs[4]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C, "hold"};
        vecs[5]  = '{1'b0, 8'hFF, 8'hFF, 16'h0001, "m1xm1"};
        vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000, "zeroA"};
        vecs[7]  = '{1'b0, 8'hFF, 8'h00, 16'h0000, "zeroB"};
        vecs[8]  = '{1'b0, 8'h01, 8'hAB, 16'hFFAB, "oneA"};
        vecs[9]  = '{1'b0, 8'h03, 8'h05, 16'h000F, "b2b0"};
        vecs[10] = '{1'b0, 8'h80, 8'h02, 16'hFF00, "b2b1"};
        vecs[11] = '{1'b0, 8'hFF, 8'h01, 16'hFFFF, "b2b2"};
        vecs[12] = '{1'b0, 8'h80, 8'h7F, 16'hC080, "minxmax"};
        vecs[13] = '{1'b0, 8'h80, 8'h80, 16'h4000, "minxmin"};
        vecs[14] = '{1'b0, 8'hFF, 8'hFF, 16'h0001, "pre_rst"};
        vecs[15] = '{1'b1, 8'h03, 8'h05, 16'h0000, "mid_rst"};
        vecs[16] = '{1'b1, 8'hFF, 8'hFF, 16'h0000, "rst_prio"};
        vecs[17] = '{1'b0, 8'h02, 8'h03, 16'h0006, "no_stale"};
`else
        vecs[0]  = '{1'b1, 8'h5A, 8'h3C, 16'h0000, "reset0"};
        vecs[1]  = '{1'b1, 8'h5A, 8'h3C, 16'h0000, "reset1"};
        vecs[2]  = '{1'b0, 8'h5A, 8'h3C, 16'h1518, "release"};
        vecs[3]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C, "12x13"};
        vecs[4]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C, "hold"};
        vecs[5]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "max"};
        vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000, "zeroA"};
        vecs[7]  = '{1'b0, 8'hFF, 8'h00, 16'h0000, "zeroB"};
        vecs[8]  = '{1'b0, 8'h01, 8'hAB, 16'h00AB, "oneA"};
        vecs[9]  = '{1'b0, 8'h03, 8'h05, 16'h000F, "b2b0"};
        vecs[10] = '{1'b0, 8'h80, 8'h02, 16'h0100, "b2b1"};
        vecs[11] = '{1'b0, 8'hFF, 8'h01, 16'h00FF, "b2b2"};
        vecs[12] = '{1'b0, 8'h80, 8'h7F, 16'h3F80, "hi_x_mid"};
        vecs[13] = '{1'b0, 8'h80, 8'h80, 16'h4000, "hi_x_hi"};
        vecs[14] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "pre_rst"};
        vecs[15] = '{1'b1, 8'h03, 8'h05, 16'h0000, "mid_rst"};
        vecs[16] = '{1'b1, 8'hFF, 8'hFF, 16'h0000, "rst_prio"};
        vecs[17] = '{1'b0, 8'h02, 8'h03, 16'h0006, "no_stale"};
`endif

        @(negedge clock);

        // Directed table; the 4-bit DUT sees the low nibbles of each vector.
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].prod,
                 vecs[i].a[3:0], vecs[i].b[3:0], vecs[i].name);
        end

        // Exhaustive 4-bit sweep, with random 8-bit operands alongside.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [7:0] idx;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            idx = 8'(i);
            step(1'b0, ra, rb, ref8(ra, rb), idx[7:4], idx[3:0], "sweep");
        end

        // Random 8-bit operands, with a sporadic reset mixed in.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] sa;
            logic [3:0] sb;
            logic       rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            sa = 4'($urandom);
            sb = 4'($urandom);
            rr = ($urandom_range(0, 63) == 0);
            step(rr, ra, rb, ref8(ra, rb), sa, sb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
